// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit paths.
package uart_pkg;

  // Receiver frame states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBrk
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

endpackage

// File: rtl/uart_rec_frame_if.sv
// Host-side and serial-line signals of the UART receiver.
interface uart_rec_frame_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic                 uart_REC_dataH;
  logic                 rec_ackH;
  logic [DATA_BITS-1:0] rec_dataH;
  logic                 rec_readyH;
  logic                 rec_frame_errH;
  logic                 rec_overrunH;
  logic                 rec_busyH;

  // Receiver side.
  modport master (
    input  uart_REC_dataH,
    input  rec_ackH,
    output rec_dataH,
    output rec_readyH,
    output rec_frame_errH,
    output rec_overrunH,
    output rec_busyH
  );

  // Line driver / host side.
  modport slave (
    output uart_REC_dataH,
    output rec_ackH,
    input  rec_dataH,
    input  rec_readyH,
    input  rec_frame_errH,
    input  rec_overrunH,
    input  rec_busyH
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Divides sys_clk down to the 16x oversample tick; clr realigns the phase.
module uart_baud_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rstH,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntLast);

  // Next count: sync clear, wrap at CLK_DIV-1, else increment.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge sys_clk) begin
    if (sys_rstH) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rec_frame.sv
// 8N1 serial receiver: 16x oversampling, LSB-first, ready/ack with sticky errors.
module uart_rec_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned DATA_BITS = 8
) (
  input logic               sys_clk,
  input logic               sys_rstH,
  uart_rec_frame_if.master  bus
);

  localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);
  localparam logic [3:0] SampMid  = 4'(MID_SAMPLE);
  localparam logic [3:0] SampLast = 4'(OVERSAMPLE - 1);

  uart_state_e          state_q, state_d;
  logic                 sync1_q, rx_s_q;
  logic [3:0]           samp_q, samp_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick, tick_clr;

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .sys_clk  (sys_clk),
    .sys_rstH (sys_rstH),
    .clr      (tick_clr),
    .tick     (tick)
  );

  // Next-state logic for the frame FSM, datapath and host flags.
  always_comb begin
    state_d  = state_q;
    samp_d   = tick ? samp_q + 4'd1 : samp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    ready_d  = ready_q & ~bus.rec_ackH;
    ferr_d   = ferr_q & ~bus.rec_ackH;
    ovr_d    = ovr_q & ~bus.rec_ackH;
    tick_clr = 1'b0;

    unique case (state_q)
      StIdle: begin
        samp_d = '0;
        if (!rx_s_q) begin
          // Restart the tick phase so sample 7 lands mid start bit.
          state_d  = StStart;
          tick_clr = 1'b1;
        end
      end
      StStart: begin
        if (tick && samp_q == SampMid) begin
          if (!rx_s_q) begin
            state_d = StData;
            bit_d   = '0;
            samp_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick && samp_q == SampLast) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BitLast) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick && samp_q == SampLast) begin
          if (rx_s_q) begin
            // An ack in this cycle frees the holding register, so the load wins.
            if (ready_q && !bus.rec_ackH) begin
              ovr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              ready_d = 1'b1;
            end
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBrk;
          end
        end
      end
      StBrk: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, synchronizer and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rstH) begin
      state_q <= StIdle;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= bus.uart_REC_dataH;
      rx_s_q  <= sync1_q;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rec_dataH      = data_q;
  assign bus.rec_readyH     = ready_q;
  assign bus.rec_frame_errH = ferr_q;
  assign bus.rec_overrunH   = ovr_q;
  assign bus.rec_busyH      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rec_frame.sv
// Directed bench for uart_rec_frame at CLK_DIV=4 (64 clocks per bit).
module tb_uart_rec_frame;

  localparam int unsigned BitClks = 64;

  logic sys_clk;
  logic sys_rstH;
  int   total;
  int   bad;

  uart_rec_frame_if #(.DATA_BITS(8)) bus ();

  uart_rec_frame #(
    .CLK_DIV   (4),
    .DATA_BITS (8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rstH (sys_rstH),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Advance n rising edges, then settle 1ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bus.uart_REC_dataH = 1'b0;
    step(BitClks);
    for (int i = 0; i < 8; i++) begin
      bus.uart_REC_dataH = d[i];
      step(BitClks);
    end
    bus.uart_REC_dataH = stop;
    step(BitClks);
  endtask

  task automatic ack_pulse();
    bus.rec_ackH = 1'b1;
    step(1);
    bus.rec_ackH = 1'b0;
  endtask

  task automatic test_reset();
    sys_rstH = 1'b1;
    step(3);
    total++; if (bus.rec_dataH !== 8'h00) begin bad++;
      $display("FAIL reset_data got %h want 00", bus.rec_dataH); end
    total++; if (bus.rec_readyH !== 1'b0) begin bad++;
      $display("FAIL reset_ready got %b want 0", bus.rec_readyH); end
    total++; if (bus.rec_frame_errH !== 1'b0) begin bad++;
      $display("FAIL reset_ferr got %b want 0", bus.rec_frame_errH); end
    total++; if (bus.rec_overrunH !== 1'b0) begin bad++;
      $display("FAIL reset_ovr got %b want 0", bus.rec_overrunH); end
    total++; if (bus.rec_busyH !== 1'b0) begin bad++;
      $display("FAIL reset_busy got %b want 0", bus.rec_busyH); end
    sys_rstH = 1'b0;
    step(4);
  endtask

  task automatic test_basic();
    fork
      send_frame(8'h55, 1'b1);
      begin
        // Stop mid-sample lands on edge 611 after the start edge.
        step(610);
        total++; if (bus.rec_readyH !== 1'b0) begin bad++;
          $display("FAIL basic_ready_early got %b want 0", bus.rec_readyH); end
        step(1);
        total++; if (bus.rec_readyH !== 1'b1) begin bad++;
          $display("FAIL basic_ready_edge got %b want 1", bus.rec_readyH); end
      end
    join
    total++; if (bus.rec_dataH !== 8'h55) begin bad++;
      $display("FAIL basic_data got %h want 55", bus.rec_dataH); end
    total++; if (bus.rec_frame_errH !== 1'b0 || bus.rec_overrunH !== 1'b0) begin bad++;
      $display("FAIL basic_flags got %b%b want 00", bus.rec_frame_errH, bus.rec_overrunH); end
    total++; if (bus.rec_busyH !== 1'b0) begin bad++;
      $display("FAIL basic_busy got %b want 0", bus.rec_busyH); end
    ack_pulse();
    total++; if (bus.rec_readyH !== 1'b0) begin bad++;
      $display("FAIL basic_ack got %b want 0", bus.rec_readyH); end
  endtask

  task automatic test_glitch();
    bus.uart_REC_dataH = 1'b0;
    step(10);
    total++; if (bus.rec_busyH !== 1'b1) begin bad++;
      $display("FAIL glitch_busy_hi got %b want 1", bus.rec_busyH); end
    step(10);
    bus.uart_REC_dataH = 1'b1;
    step(60);
    total++; if (bus.rec_busyH !== 1'b0) begin bad++;
      $display("FAIL glitch_busy_lo got %b want 0", bus.rec_busyH); end
    total++; if (bus.rec_readyH !== 1'b0) begin bad++;
      $display("FAIL glitch_ready got %b want 0", bus.rec_readyH); end
  endtask

  task automatic test_frame_err();
    send_frame(8'hA3, 1'b0);
    step(200);
    total++; if (bus.rec_frame_errH !== 1'b1) begin bad++;
      $display("FAIL ferr_flag got %b want 1", bus.rec_frame_errH); end
    total++; if (bus.rec_readyH !== 1'b0) begin bad++;
      $display("FAIL ferr_ready got %b want 0", bus.rec_readyH); end
    total++; if (bus.rec_dataH !== 8'h55) begin bad++;
      $display("FAIL ferr_data got %h want 55", bus.rec_dataH); end
    total++; if (bus.rec_busyH !== 1'b1) begin bad++;
      $display("FAIL ferr_brk_busy got %b want 1", bus.rec_busyH); end
    bus.uart_REC_dataH = 1'b1;
    step(4);
    total++; if (bus.rec_busyH !== 1'b0) begin bad++;
      $display("FAIL ferr_brk_exit got %b want 0", bus.rec_busyH); end
    ack_pulse();
    total++; if (bus.rec_frame_errH !== 1'b0) begin bad++;
      $display("FAIL ferr_ack got %b want 0", bus.rec_frame_errH); end
  endtask

  task automatic test_overrun();
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    total++; if (bus.rec_dataH !== 8'h01) begin bad++;
      $display("FAIL ovr_data got %h want 01", bus.rec_dataH); end
    total++; if (bus.rec_readyH !== 1'b1) begin bad++;
      $display("FAIL ovr_ready got %b want 1", bus.rec_readyH); end
    total++; if (bus.rec_overrunH !== 1'b1) begin bad++;
      $display("FAIL ovr_flag got %b want 1", bus.rec_overrunH); end
    ack_pulse();
    total++; if (bus.rec_readyH !== 1'b0 || bus.rec_overrunH !== 1'b0) begin bad++;
      $display("FAIL ovr_ack got %b%b want 00", bus.rec_readyH, bus.rec_overrunH); end
  endtask

  task automatic test_ack_on_load();
    send_frame(8'h01, 1'b1);
    fork
      send_frame(8'h02, 1'b1);
      begin
        step(610);
        bus.rec_ackH = 1'b1;
        step(1);
        bus.rec_ackH = 1'b0;
        total++; if (bus.rec_readyH !== 1'b1) begin bad++;
          $display("FAIL ackload_ready got %b want 1", bus.rec_readyH); end
        total++; if (bus.rec_dataH !== 8'h02) begin bad++;
          $display("FAIL ackload_data got %h want 02", bus.rec_dataH); end
        total++; if (bus.rec_overrunH !== 1'b0) begin bad++;
          $display("FAIL ackload_ovr got %b want 0", bus.rec_overrunH); end
      end
    join
  endtask

  task automatic test_reset_mid();
    bus.uart_REC_dataH = 1'b0;
    step(BitClks);
    for (int i = 0; i < 4; i++) begin
      bus.uart_REC_dataH = 1'b1;
      step(BitClks);
    end
    step(BitClks / 2);
    total++; if (bus.rec_busyH !== 1'b1) begin bad++;
      $display("FAIL rstmid_busy_pre got %b want 1", bus.rec_busyH); end
    sys_rstH = 1'b1;
    step(1);
    total++; if (bus.rec_dataH !== 8'h00 || bus.rec_readyH !== 1'b0) begin bad++;
      $display("FAIL rstmid_out got %h/%b want 00/0", bus.rec_dataH, bus.rec_readyH); end
    total++; if (bus.rec_busyH !== 1'b0 || bus.rec_frame_errH !== 1'b0
                 || bus.rec_overrunH !== 1'b0) begin bad++;
      $display("FAIL rstmid_flags got %b%b%b want 000", bus.rec_busyH,
               bus.rec_frame_errH, bus.rec_overrunH); end
    sys_rstH = 1'b0;
    step(BitClks * 5);
    send_frame(8'h3C, 1'b1);
    total++; if (bus.rec_dataH !== 8'h3C) begin bad++;
      $display("FAIL rstmid_data got %h want 3c", bus.rec_dataH); end
    total++; if (bus.rec_readyH !== 1'b1) begin bad++;
      $display("FAIL rstmid_ready got %b want 1", bus.rec_readyH); end
    total++; if (bus.rec_frame_errH !== 1'b0 || bus.rec_overrunH !== 1'b0) begin bad++;
      $display("FAIL rstmid_errs got %b%b want 00", bus.rec_frame_errH, bus.rec_overrunH); end
  endtask

  initial begin
    total              = 0;
    bad                = 0;
    sys_rstH           = 1'b1;
    bus.uart_REC_dataH = 1'b1;
    bus.rec_ackH       = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_ack_on_load();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
